// File: rtl/unidade_controle_mc.sv
// rtl/unidade_controle_mc.sv - multicycle Moore control unit for the 8-bit RISC-V-subset datapath
module unidade_controle_mc #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Z,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ULAControl,
    output logic       instr_done,
    output logic       halted
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ, S_HALT
    } state_t;

    state_t     state, nxt, tgt;
    logic       pcupdate_r, branch_r, adrsrc_r, memwrite_r, irwrite_r, regwrite_r;
    logic       done_r, halted_r;
    logic [1:0] resultsrc_r, srca_r, srcb_r, aluop_r;
    logic       legal;

    assign legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                   (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);

    // Next-state selection; reset folds into the target so outputs can be registered from it
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXECUTER;
                    OP_I:         nxt = S_EXECUTEI;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_JAL:       nxt = S_JAL;
                    default:      nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: nxt = S_FETCH;
            S_EXECUTER: nxt = S_ALUWB;
            S_EXECUTEI: nxt = S_ALUWB;
            S_JAL:      nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BEQ:      nxt = S_FETCH;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_FETCH;
        endcase
        tgt = rst ? S_FETCH : nxt;
    end

    // State register plus Moore outputs registered from the state being entered
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= nxt;
        pcupdate_r  <= 1'b0;
        branch_r    <= 1'b0;
        adrsrc_r    <= 1'b0;
        memwrite_r  <= 1'b0;
        irwrite_r   <= 1'b0;
        regwrite_r  <= 1'b0;
        done_r      <= 1'b0;
        halted_r    <= 1'b0;
        resultsrc_r <= 2'b00;
        srca_r      <= 2'b00;
        srcb_r      <= 2'b00;
        aluop_r     <= 2'b00;
        case (tgt)
            S_FETCH: begin
                irwrite_r   <= 1'b1;
                srcb_r      <= 2'b10;
                resultsrc_r <= 2'b10;
                pcupdate_r  <= 1'b1;
            end
            S_DECODE: begin
                srca_r <= 2'b01;
                srcb_r <= 2'b01;
            end
            S_MEMADR: begin
                srca_r <= 2'b10;
                srcb_r <= 2'b01;
            end
            S_MEMREAD:  adrsrc_r <= 1'b1;
            S_MEMWB: begin
                resultsrc_r <= 2'b01;
                regwrite_r  <= 1'b1;
                done_r      <= 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_r   <= 1'b1;
                memwrite_r <= 1'b1;
                done_r     <= 1'b1;
            end
            S_EXECUTER: begin
                srca_r  <= 2'b10;
                aluop_r <= 2'b10;
            end
            S_EXECUTEI: begin
                srca_r  <= 2'b10;
                srcb_r  <= 2'b01;
                aluop_r <= 2'b10;
            end
            S_ALUWB: begin
                regwrite_r <= 1'b1;
                done_r     <= 1'b1;
            end
            S_JAL: begin
                srca_r     <= 2'b01;
                srcb_r     <= 2'b10;
                pcupdate_r <= 1'b1;
            end
            S_BEQ: begin
                srca_r   <= 2'b10;
                aluop_r  <= 2'b01;
                branch_r <= 1'b1;
                done_r   <= 1'b1;
            end
            S_HALT:     halted_r <= 1'b1;
            default:    halted_r <= 1'b0;
        endcase
    end

    // ALU decoder: funct7b5 only selects sub for R-type, where op[5] is set
    always_comb begin
        ULAControl = 3'b000;
        case (aluop_r)
            2'b01: ULAControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ULAControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ULAControl = 3'b101;
                    3'b110:  ULAControl = 3'b011;
                    3'b111:  ULAControl = 3'b010;
                    default: ULAControl = 3'b000;
                endcase
            end
            default: ULAControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Write enables are suppressed in the reset cycle; branch uses the live zero flag
    assign PCWrite    = ~rst & (pcupdate_r | (branch_r & Z));
    assign IRWrite    = ~rst & irwrite_r;
    assign MemWrite   = ~rst & memwrite_r;
    assign RegWrite   = ~rst & regwrite_r;
    assign instr_done = ~rst & (done_r | ((state == S_DECODE) & ~legal & ~ILLEGAL_HALT));
    assign AdrSrc     = adrsrc_r;
    assign ResultSrc  = resultsrc_r;
    assign ULASrcA    = srca_r;
    assign ULASrcB    = srcb_r;
    assign halted     = halted_r;
endmodule

// File: tb/tb_unidade_controle_mc.sv
// tb/tb_unidade_controle_mc.sv - self-checking bench for unidade_controle_mc
module tb_unidade_controle_mc;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Z;

    logic       pcw0, adr0, mw0, irw0, rw0, done0, hlt0;
    logic [1:0] rs0, sa0, sb0, imm0;
    logic [2:0] alu0;
    logic       pcw1, adr1, mw1, irw1, rw1, done1, hlt1;
    logic [1:0] rs1, sa1, sb1, imm1;
    logic [2:0] alu1;

    unidade_controle_mc #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Z(Z),
        .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(rs0),
        .ULASrcA(sa0), .ULASrcB(sb0), .ImmSrc(imm0), .RegWrite(rw0), .ULAControl(alu0),
        .instr_done(done0), .halted(hlt0));

    unidade_controle_mc #(.ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Z(Z),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .ResultSrc(rs1),
        .ULASrcA(sa1), .ULASrcB(sb1), .ImmSrc(imm1), .RegWrite(rw1), .ULAControl(alu1),
        .instr_done(done1), .halted(hlt1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic       rw;
        logic [2:0] alu;
        logic       done, halted;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z;
        int         cyc;
        logic [2:0] alu;
        logic       pcw;
        int         rw;
        logic [1:0] imm;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic bit is_legal(logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Phase letters per instruction: F fetch, D decode, M address, R read, W load writeback,
    // S store, X reg-reg exec, Y reg-imm exec, J jump, A alu writeback, B branch
    function automatic string phases_of(logic [6:0] o);
        case (o)
            7'b0000011: return "FDMRW";
            7'b0100011: return "FDMS";
            7'b0110011: return "FDXA";
            7'b0010011: return "FDYA";
            7'b1101111: return "FDJA";
            7'b1100011: return "FDB";
            default:    return "FD";
        endcase
    endfunction

    function automatic logic [2:0] alu_func(logic [6:0] o, logic [2:0] f3, logic f7);
        if (f3 == 3'd0) return (o[5] && f7) ? 3'd1 : 3'd0;
        if (f3 == 3'd2) return 3'd5;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd7) return 3'd2;
        return 3'd0;
    endfunction

    function automatic outs_t expect_out(byte p, logic [6:0] o, logic [2:0] f3, logic f7,
                                         logic z, bit ih, logic r);
        outs_t e = '0;
        if (o == 7'b0100011) e.imm = 2'd1;
        else if (o == 7'b1100011) e.imm = 2'd2;
        else if (o == 7'b1101111) e.imm = 2'd3;
        case (p)
            "F": begin e.irw = 1; e.sb = 2; e.rs = 2; e.pcw = 1; end
            "D": begin e.sa = 1; e.sb = 1; e.done = !is_legal(o) && !ih; end
            "M": begin e.sa = 2; e.sb = 1; end
            "R": e.adr = 1;
            "W": begin e.rs = 1; e.rw = 1; e.done = 1; end
            "S": begin e.adr = 1; e.mw = 1; e.done = 1; end
            "X": begin e.sa = 2; e.alu = alu_func(o, f3, f7); end
            "Y": begin e.sa = 2; e.sb = 1; e.alu = alu_func(o, f3, f7); end
            "A": begin e.rw = 1; e.done = 1; end
            "J": begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            "B": begin e.sa = 2; e.alu = 3'd1; e.pcw = z; e.done = 1; end
            "H": e.halted = 1;
            default: e = '0;
        endcase
        if (r) begin e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0; e.done = 0; end
        return e;
    endfunction

    function automatic outs_t act0();
        return '{pcw0, adr0, mw0, irw0, rs0, sa0, sb0, imm0, rw0, alu0, done0, hlt0};
    endfunction

    function automatic outs_t act1();
        return '{pcw1, adr1, mw1, irw1, rs1, sa1, sb1, imm1, rw1, alu1, done1, hlt1};
    endfunction

    task automatic chk(string name, outs_t act, outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic chk_val(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_chk(string tag, byte p0, byte p1);
        @(negedge clk);
        chk($sformatf("%s_%c_d0", tag, p0), act0(), expect_out(p0, op, funct3, funct7b5, Z, 1'b0, rst));
        chk($sformatf("%s_%c_d1", tag, p1), act1(), expect_out(p1, op, funct3, funct7b5, Z, 1'b1, rst));
        step();
    endtask

    task automatic run_entry(int idx, vec_t v);
        int   cyc = 0;
        int   rw = 0;
        logic [2:0] alu_s = 3'b111;
        logic pcw_s = 1'b1;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; Z = v.z;
        @(negedge clk);
        chk($sformatf("t%0d_fetch", idx), act0(), expect_out("F", op, funct3, funct7b5, Z, 1'b0, 1'b0));
        chk_val($sformatf("t%0d_imm", idx), int'(imm0), int'(v.imm));
        step();
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            if (k <= 2) begin alu_s = alu0; pcw_s = pcw0; end
            rw += int'(rw0);
            if (done0) begin
                cyc = k + 1;
                step();
                break;
            end
            step();
        end
        chk_val($sformatf("t%0d_cycles", idx), cyc, v.cyc);
        chk_val($sformatf("t%0d_alu", idx), int'(alu_s), int'(v.alu));
        chk_val($sformatf("t%0d_pcw", idx), int'(pcw_s), int'(v.pcw));
        chk_val($sformatf("t%0d_regwrites", idx), rw, v.rw);
    endtask

    vec_t tbl[14];

    initial begin
        string ph;
        bit    h1;
        int    rwcount;
        tbl[0]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 3'd0, 1'b0, 1, 2'd0};
        tbl[1]  = '{7'b0100011, 3'd2, 1'b1, 1'b1, 4, 3'd0, 1'b0, 0, 2'd1};
        tbl[2]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 3'd1, 1'b0, 1, 2'd0};
        tbl[3]  = '{7'b0110011, 3'd0, 1'b0, 1'b1, 4, 3'd0, 1'b0, 1, 2'd0};
        tbl[4]  = '{7'b0110011, 3'd2, 1'b0, 1'b0, 4, 3'd5, 1'b0, 1, 2'd0};
        tbl[5]  = '{7'b0110011, 3'd6, 1'b0, 1'b0, 4, 3'd3, 1'b0, 1, 2'd0};
        tbl[6]  = '{7'b0110011, 3'd7, 1'b1, 1'b0, 4, 3'd2, 1'b0, 1, 2'd0};
        tbl[7]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 3'd0, 1'b0, 1, 2'd0};
        tbl[8]  = '{7'b0010011, 3'd2, 1'b0, 1'b0, 4, 3'd5, 1'b0, 1, 2'd0};
        tbl[9]  = '{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 3'd1, 1'b1, 0, 2'd2};
        tbl[10] = '{7'b1100011, 3'd0, 1'b0, 1'b0, 3, 3'd1, 1'b0, 0, 2'd2};
        tbl[11] = '{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 3'd0, 1'b1, 1, 2'd3};
        tbl[12] = '{7'b0110011, 3'd4, 1'b0, 1'b0, 4, 3'd0, 1'b0, 1, 2'd0};
        tbl[13] = '{7'b1111111, 3'd0, 1'b0, 1'b0, 2, 3'd0, 1'b0, 0, 2'd0};

        // Reset: write enables held low while rst is high, even in FETCH
        rst = 1; op = 7'b0000011; funct3 = 0; funct7b5 = 0; Z = 1;
        step();
        cyc_chk("reset", "F", "F");
        rst = 0;

        foreach (tbl[i]) run_entry(i, tbl[i]);

        // Reset in MEMREAD of a lw: next cycle is FETCH, RegWrite never asserted
        op = 7'b0000011; funct3 = 3'd2; Z = 1; rwcount = 0;
        cyc_chk("midrst", "F", "H");
        cyc_chk("midrst", "D", "H");
        cyc_chk("midrst", "M", "H");
        rst = 1;
        @(negedge clk);
        rwcount += int'(rw0);
        step();
        rst = 0;
        cyc_chk("midrst_after", "F", "F");
        @(negedge clk);
        rwcount += int'(rw0);
        chk_val("midrst_regwrite", rwcount, 0);
        chk("midrst_decode", act0(), expect_out("D", op, funct3, funct7b5, Z, 1'b0, 1'b0));
        step();
        cyc_chk("midrst", "M", "M");
        cyc_chk("midrst", "R", "R");
        cyc_chk("midrst", "W", "W");

        // Illegal opcode: dut0 loops in two cycles, dut1 halts until reset
        op = 7'b1111111;
        cyc_chk("illegal", "F", "F");
        cyc_chk("illegal", "D", "D");
        for (int i = 0; i < 10; i++) cyc_chk("halt", (i % 2 == 0) ? "F" : "D", "H");
        rst = 1;
        cyc_chk("halt_rst", "F", "H");
        rst = 0;

        // Random instruction stream against the phase model
        h1 = 0;
        for (int n = 0; n < 250; n++) begin
            if (h1 && $urandom_range(0, 3) == 0) begin
                rst = 1;
                cyc_chk("rnd_rst", "F", "H");
                rst = 0;
                h1 = 0;
            end
            case ($urandom_range(0, 12))
                0, 1:    op = 7'b0000011;
                2, 3:    op = 7'b0100011;
                4, 5:    op = 7'b0110011;
                6, 7:    op = 7'b0010011;
                8, 9:    op = 7'b1100011;
                10, 11:  op = 7'b1101111;
                default: begin
                    op = 7'($urandom);
                    while (is_legal(op)) op = 7'($urandom);
                end
            endcase
            funct3 = 3'($urandom);
            funct7b5 = 1'($urandom);
            ph = phases_of(op);
            for (int k = 0; k < ph.len(); k++) begin
                Z = 1'($urandom);
                cyc_chk("rnd", ph[k], h1 ? "H" : ph[k]);
            end
            if (!is_legal(op)) h1 = 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_controle_mc.md
Name: unidade_controle_mc

Overview:
- Multicycle control unit for the 8-bit RISC-V-subset datapath.
- Sits directly upstream of the ALU and drives its 3-bit operation select, `ULAControl`. It consumes the ALU zero flag `Z` for branches.
- Sequences every instruction through a Moore FSM.
- Drives PC, instruction-register, memory, register-file and operand-mux controls.

Parameters:
- ILLEGAL_HALT, 0, 0 = an unsupported opcode in DECODE returns to FETCH; 1 = enter HALT and stay there until reset.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- Z  input  1  ALU zero flag, combinational from the ALU
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ULASrcA  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = A (rs1)
- ULASrcB  output  2  SrcB select: 00 = WriteData (rs2), 01 = ImmExt, 10 = constant 4
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  output  1  register file write enable
- ULAControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  output  1  one-cycle pulse in the last state of each instruction
- halted  output  1  high while in HALT

Behaviour:
- Reset: `clk` and `rst` only; `rst` is synchronous and active-high.
  - A rising edge with `rst`=1 loads state FETCH, from any state, including mid-instruction.
  - While `rst`=1, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0 combinationally.
  - After reset, other outputs take their FETCH values; halted=0.
- Opcodes:
  - lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Transitions, one state per clock:
  - FETCH -> DECODE
  - DECODE -> MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I), BEQ, JAL; any other opcode -> FETCH, or HALT if ILLEGAL_HALT=1.
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw)
  - MEMREAD -> MEMWB -> FETCH
  - MEMWRITE -> FETCH
  - EXECUTER, EXECUTEI, JAL -> ALUWB -> FETCH
  - BEQ -> FETCH
  - HALT -> HALT
- Moore outputs per state (unlisted outputs are 0):
  - FETCH: IRWrite=1, ULASrcA=00, ULASrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ULASrcA=01, ULASrcB=01, ALUOp=00.
  - MEMADR: ULASrcA=10, ULASrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ULASrcA=10, ULASrcB=00, ALUOp=10.
  - EXECUTEI: ULASrcA=10, ULASrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ULASrcA=01, ULASrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ULASrcA=10, ULASrcB=00, ALUOp=01, Branch=1.
- PCWrite = PCUpdate | (Branch & Z). Z is sampled combinationally in the same cycle; no registering.
- ALU decoder (combinational, internal ALUOp):
  - ALUOp 00 -> 000; 01 -> 001.
  - ALUOp 10, by funct3:
    - 000 -> 001 if op[5] & funct7b5, else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - any other funct3 -> 000
  - ALUOp 11 -> 000.
- ImmSrc decoded from op regardless of state:
  - lw and I-ALU 00, sw 01, beq 10, jal 11, other 00.
- instr_done = 1 in MEMWB, MEMWRITE, ALUWB and BEQ, and in DECODE when the opcode is illegal and ILLEGAL_HALT=0.
- Cycle counts per instruction, FETCH through the return to FETCH:
  - lw 5; sw 4; R 4; I 4; jal 4; beq 3.
- Illegal opcode costs 2 cycles with no register or memory write.
- op/funct inputs are held stable by the IR from DECODE onward. The FSM must not depend on them in FETCH.

Test Plan:
- Reset mid-instruction: assert rst for 1 clk in MEMREAD of a lw -> state FETCH next cycle; RegWrite never pulses; PCWrite=0 while rst=1.
- lw (op=0000011): 5 cycles.
  - ULAControl=000 in FETCH, DECODE and MEMADR.
  - AdrSrc=1 in MEMREAD; RegWrite=1 with ResultSrc=01 in cycle 5.
  - instr_done=1 only in cycle 5.
- R-type sub: op=0110011, funct3=000, funct7b5=1 -> ULAControl=001 in EXECUTER. With funct7b5=0 -> 000.
- R-type slt/or/and: funct3=010/110/111 -> ULAControl=101/011/010 in EXECUTER; RegWrite in ALUWB.
- I-type addi with funct7b5=1 (op[5]=0) -> ULAControl=000 in EXECUTEI (no sub); ImmSrc=00.
- beq: Z=1 -> PCWrite=1 in BEQ with ULAControl=001; Z=0 -> PCWrite=0. Back to FETCH after 3 cycles.
- jal: PCWrite=1 in the JAL state, ImmSrc=11, RegWrite=1 in ALUWB.
- Illegal op=1111111:
  - ILLEGAL_HALT=0 -> back in FETCH after 2 cycles, no writes.
  - ILLEGAL_HALT=1 -> halted=1 and held for 10 clks; a rst pulse returns to FETCH with halted=0.
